// File: rtl/ysyx_040750_clint_pkg.sv
// ysyx_040750_clint_pkg
// Shared definitions for the core-local interruptor (CLINT).
// - Register offsets relative to BASE_ADDR.
// - Reset value of mtimecmp.
// - FSM state type of the MMIO port.
// - Byte-mask merge helper used for register writes.
// Optional feature macro: YSYX_040750_CLINT_MSIP_EN (maps msip at MSIP_OFF).
package ysyx_040750_clint_pkg;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    // All-ones keeps the timer interrupt quiet until software programs a deadline.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_e;

    // Replace each enabled byte of old_val with the matching byte of wdata.
    function automatic logic [63:0] apply_wmask(input logic [63:0] old_val,
                                                input logic [63:0] wdata,
                                                input logic [7:0]  wmask);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_040750_clint_prescaler.sv
// ysyx_040750_clint_prescaler
// Divides the core clock down to the mtime increment rate.
// - The counter runs 0..MTIME_DIV-1.
// - O_tick is high while the count sits at MTIME_DIV-1; the count then returns to 0.
// - With MTIME_DIV = 1 the count stays at 0 and O_tick is high every cycle.
// Ports:
//   I_clk    core clock
//   I_rst_n  asynchronous active-low reset (count -> 0)
//   O_tick   one-cycle increment strobe for mtime
module ysyx_040750_clint_prescaler #(
    parameter int unsigned MTIME_DIV = 1    // legal range 1..65535
) (
    input  logic I_clk,
    input  logic I_rst_n,
    output logic O_tick
);

    localparam logic [15:0] LAST = 16'(MTIME_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        O_tick = (cnt_q == LAST);
        cnt_d  = O_tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_040750_clint.sv
// ysyx_040750_clint
// Core-local interruptor owning the machine timer (mtime / mtimecmp).
// It drives the registered timer-pending level O_mtip.
//
// MMIO port handshake rules:
// - A request transfers on a cycle where I_req_valid and O_req_ready are both high.
// - The access is performed in that same cycle; reads return pre-tick values.
// - O_resp_valid rises on the next cycle.
// - The response (O_resp_valid, O_resp_rdata, O_resp_err) is held stable
//   until the cycle where I_resp_ready is high.
// - O_req_ready is low while a response is outstanding, so at most one
//   request is in flight.
//
// Ports:
//   I_clk, I_rst_n             clock, asynchronous active-low reset
//   I_req_valid / O_req_ready  request handshake
//   I_req_wen                  1 = write, 0 = read
//   I_req_addr                 byte address (8-byte aligned)
//   I_req_wdata, I_req_wmask   write data and byte enables
//   O_resp_valid/I_resp_ready  response handshake
//   O_resp_rdata               read data (0 for writes and errors)
//   O_resp_err                 unmapped or misaligned access
//   O_mtip                     registered (mtime >= mtimecmp)
//   O_msip                     software interrupt bit (only with YSYX_040750_CLINT_MSIP_EN)
//
// Optional feature macro: YSYX_040750_CLINT_MSIP_EN.
// - Maps a 1-bit msip register at offset 0x0000 and adds port O_msip.
module ysyx_040750_clint
    import ysyx_040750_clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned MTIME_DIV = 1
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic        I_req_wen,
    input  logic [63:0] I_req_addr,
    input  logic [63:0] I_req_wdata,
    input  logic [7:0]  I_req_wmask,
    output logic        O_resp_valid,
    input  logic        I_resp_ready,
    output logic [63:0] O_resp_rdata,
    output logic        O_resp_err,
    output logic        O_mtip
`ifdef YSYX_040750_CLINT_MSIP_EN
    ,
    output logic        O_msip
`endif
);

    logic         tick;
    clint_state_e state_q, state_d;
    logic [63:0]  mtime_q, mtime_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    logic [63:0]  rdata_q, rdata_d;
    logic         err_q, err_d;
    logic         mtip_q;
    logic         hs;

    logic [63:0]  offset;
    logic         in_window;
    logic         aligned;
    logic         sel_mtime;
    logic         sel_mtimecmp;
    logic         sel_msip;
    logic         addr_err;

`ifdef YSYX_040750_CLINT_MSIP_EN
    logic         msip_q, msip_d;
`endif

    ysyx_040750_clint_prescaler #(
        .MTIME_DIV (MTIME_DIV)
    ) u_prescaler (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .O_tick  (tick)
    );

    // Address decode. The window check on the upper offset bits stops
    // aliasing of the 16-bit register offsets across the whole address space.
    always_comb begin
        offset       = I_req_addr - BASE_ADDR;
        in_window    = (offset[63:16] == 48'd0);
        aligned      = (I_req_addr[2:0] == 3'b000);
        sel_mtime    = in_window && aligned && (offset[15:0] == MTIME_OFF);
        sel_mtimecmp = in_window && aligned && (offset[15:0] == MTIMECMP_OFF);
`ifdef YSYX_040750_CLINT_MSIP_EN
        sel_msip     = in_window && aligned && (offset[15:0] == MSIP_OFF);
`else
        sel_msip     = 1'b0;
`endif
        addr_err     = !(sel_mtime || sel_mtimecmp || sel_msip);
    end

    // FSM: state register
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (I_req_valid)  state_d = RESP;
            RESP:    if (I_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        O_req_ready  = (state_q == IDLE);
        O_resp_valid = (state_q == RESP);
    end

    assign hs = I_req_valid && O_req_ready;

    // Register and response next-state.
    // A write to mtime overrides the tick increment in the same cycle;
    // bytes left unmasked keep the pre-increment value.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
`ifdef YSYX_040750_CLINT_MSIP_EN
        msip_d     = msip_q;
`endif
        if (hs) begin
            err_d   = addr_err;
            rdata_d = 64'd0;
            if (!I_req_wen) begin
                if (sel_mtime)    rdata_d = mtime_q;
                if (sel_mtimecmp) rdata_d = mtimecmp_q;
`ifdef YSYX_040750_CLINT_MSIP_EN
                if (sel_msip)     rdata_d = {63'd0, msip_q};
`endif
            end else begin
                if (sel_mtime)    mtime_d    = apply_wmask(mtime_q, I_req_wdata, I_req_wmask);
                if (sel_mtimecmp) mtimecmp_d = apply_wmask(mtimecmp_q, I_req_wdata, I_req_wmask);
`ifdef YSYX_040750_CLINT_MSIP_EN
                if (sel_msip && I_req_wmask[0]) msip_d = I_req_wdata[0];
`endif
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            rdata_q    <= 64'd0;
            err_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            // Compares the current register values, so mtip lags any
            // register change by one cycle.
            mtip_q     <= (mtime_q >= mtimecmp_q);
        end
    end

`ifdef YSYX_040750_CLINT_MSIP_EN
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            msip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
        end
    end

    assign O_msip = msip_q;
`endif

    assign O_resp_rdata = rdata_q;
    assign O_resp_err   = err_q;
    assign O_mtip       = mtip_q;

endmodule
